// File: rtl/corr_bht.sv
// corr_bht: correlating branch history table with gshare/concat indexing, stats and debug readout
module corr_bht #(
    parameter int PC_BITS   = 2,
    parameter int HIST_BITS = 2,
    parameter int CTR_BITS  = 2,
    parameter int GSHARE    = 0,
    localparam int IDX_W    = (GSHARE != 0) ? PC_BITS : PC_BITS + HIST_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pred_valid,
    input  logic [PC_BITS-1:0]   pred_pc,
    output logic                 pred_out_valid,
    output logic                 pred_taken,
    output logic [IDX_W-1:0]     pred_idx,
    input  logic                 upd_valid,
    input  logic [IDX_W-1:0]     upd_idx,
    input  logic                 upd_outcome,
    input  logic                 upd_pred,
    output logic [HIST_BITS-1:0] laststates,
    input  logic [IDX_W-1:0]     dbg_idx,
    output logic [CTR_BITS-1:0]  dbg_ctr,
    output logic [15:0]          stat_upd,
    output logic [15:0]          stat_miss
);
    localparam logic [CTR_BITS-1:0] WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    logic [CTR_BITS-1:0] ctr_q [2**IDX_W];
    logic [CTR_BITS-1:0] ctr_cur, ctr_nxt;
    logic [IDX_W-1:0]    idx;
    generate
        if (GSHARE != 0) begin : g_xor
            assign idx = pred_pc ^ IDX_W'(laststates);
        end else begin : g_cat
            assign idx = {pred_pc, laststates};
        end
    endgenerate
    always_comb begin
        ctr_cur = ctr_q[upd_idx];
        ctr_nxt = upd_outcome ? ((&ctr_cur) ? ctr_cur : ctr_cur + 1'b1)
                              : ((|ctr_cur) ? ctr_cur - 1'b1 : ctr_cur);
    end
    assign dbg_ctr = ctr_q[dbg_idx];
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 2**IDX_W; i++) ctr_q[i] <= WNT;
            laststates     <= '0;
            pred_out_valid <= 1'b0;
            pred_taken     <= 1'b0;
            pred_idx       <= '0;
            stat_upd       <= '0;
            stat_miss      <= '0;
        end else begin
            pred_out_valid <= pred_valid;
            if (pred_valid) begin
                pred_taken <= ctr_q[idx][CTR_BITS-1];
                pred_idx   <= idx;
            end
            if (upd_valid) begin
                ctr_q[upd_idx] <= ctr_nxt;
                laststates     <= (laststates << 1) | HIST_BITS'(upd_outcome);
                stat_upd       <= (&stat_upd) ? stat_upd : stat_upd + 16'd1;
                if (upd_outcome != upd_pred && !(&stat_miss)) stat_miss <= stat_miss + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_corr_bht.sv
// tb_corr_bht: randomized and directed checks of corr_bht against a behavioural model
module tb_corr_bht;
    logic clk = 0;
    logic reset = 1, pred_valid = 0, upd_valid = 0, upd_outcome = 0, upd_pred = 0;
    logic [1:0] pred_pc = 0;
    logic [3:0] upd_idx = 0, dbg_idx = 0, pred_idx;
    logic [1:0] laststates, dbg_ctr, pred_idx_x, laststates_x, dbg_ctr_x;
    logic pred_out_valid, pred_taken, pov_x, pt_x;
    logic [15:0] stat_upd, stat_miss, su_x, sm_x;
    int n_pass = 0, n_chk = 0;
    int m_ctr [16];
    int m_ghr, m_pidx, m_xidx, m_upd, m_miss;
    bit m_pov, m_pt;

    always #5 clk = ~clk;

    corr_bht dut (
        .clk(clk), .reset(reset), .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_out_valid(pred_out_valid), .pred_taken(pred_taken), .pred_idx(pred_idx),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_outcome(upd_outcome), .upd_pred(upd_pred),
        .laststates(laststates), .dbg_idx(dbg_idx), .dbg_ctr(dbg_ctr),
        .stat_upd(stat_upd), .stat_miss(stat_miss)
    );

    corr_bht #(.GSHARE(1)) dut_x (
        .clk(clk), .reset(reset), .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_out_valid(pov_x), .pred_taken(pt_x), .pred_idx(pred_idx_x),
        .upd_valid(upd_valid), .upd_idx(upd_idx[1:0]), .upd_outcome(upd_outcome), .upd_pred(upd_pred),
        .laststates(laststates_x), .dbg_idx(dbg_idx[1:0]), .dbg_ctr(dbg_ctr_x),
        .stat_upd(su_x), .stat_miss(sm_x)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            foreach (m_ctr[i]) m_ctr[i] = 1;
            m_ghr = 0; m_pidx = 0; m_xidx = 0; m_upd = 0; m_miss = 0; m_pov = 0; m_pt = 0;
        end else begin
            m_pov = pred_valid;
            if (pred_valid) begin
                m_pidx = pred_pc * 4 + m_ghr;
                m_xidx = pred_pc ^ m_ghr;
                m_pt   = m_ctr[m_pidx] >= 2;
            end
            if (upd_valid) begin
                m_ctr[upd_idx] = upd_outcome ? (m_ctr[upd_idx] < 3 ? m_ctr[upd_idx] + 1 : 3)
                                             : (m_ctr[upd_idx] > 0 ? m_ctr[upd_idx] - 1 : 0);
                m_ghr  = (m_ghr * 2 + upd_outcome) % 4;
                m_upd  = m_upd < 65535 ? m_upd + 1 : 65535;
                if (upd_outcome != upd_pred) m_miss = m_miss < 65535 ? m_miss + 1 : 65535;
            end
        end
        #1;
    endtask

    task automatic check_all();
        check("pov", pred_out_valid, m_pov);
        check("ptaken", pred_taken, m_pt);
        check("pidx", pred_idx, m_pidx);
        check("pidx_gshare", pred_idx_x, m_xidx);
        check("ghr", laststates, m_ghr);
        check("stat_upd", stat_upd, m_upd);
        check("stat_miss", stat_miss, m_miss);
        dbg_idx = 4'($urandom);
        #1;
        check("dbg_ctr", dbg_ctr, m_ctr[dbg_idx]);
    endtask

    task automatic upd(input logic [3:0] i, input logic o, input logic p);
        upd_valid = 1; upd_idx = i; upd_outcome = o; upd_pred = p;
        tick();
        upd_valid = 0;
    endtask

    task automatic do_reset();
        reset = 0; pred_valid = 0; upd_valid = 0;
        tick();
        reset = 1;
    endtask

    int sat_up [4] = '{2, 3, 3, 3};
    int sat_dn [5] = '{2, 1, 0, 0, 0};
    bit miss_pat [10] = '{0, 1, 0, 0, 1, 0, 0, 0, 1, 0};

    initial begin
        do_reset();
        for (int i = 0; i < 16; i++) begin
            dbg_idx = 4'(i); #1;
            check("rst_ctr", dbg_ctr, 2'b01);
        end
        check("rst_ghr", laststates, 0);
        check("rst_upd", stat_upd, 0);
        check("rst_miss", stat_miss, 0);
        check("rst_pov", pred_out_valid, 0);

        dbg_idx = 5;
        for (int i = 0; i < 4; i++) begin upd(5, 1, 1); #1; check("sat_up", dbg_ctr, sat_up[i]); end
        for (int i = 0; i < 5; i++) begin upd(5, 0, 0); #1; check("sat_dn", dbg_ctr, sat_dn[i]); end
        for (int i = 0; i < 16; i++) if (i != 5) begin
            dbg_idx = 4'(i); #1;
            check("sat_other", dbg_ctr, 2'b01);
        end

        do_reset();
        upd(0, 1, 1);
        upd(1, 0, 0);
        check("hist_ghr", laststates, 2'b10);
        pred_valid = 1; pred_pc = 3;
        tick();
        pred_valid = 0;
        check("hist_idx_cat", pred_idx, 4'b1110);
        check("hist_idx_xor", pred_idx_x, 2'b01);
        check_all();

        do_reset();
        upd(0, 1, 1);
        upd(0, 1, 1);
        pred_valid = 1; pred_pc = 1; upd_valid = 1; upd_idx = 7; upd_outcome = 1; upd_pred = 0;
        tick();
        upd_valid = 0;
        dbg_idx = 7; #1;
        check("rbw_pt", pred_taken, 0);
        check("rbw_idx", pred_idx, 7);
        check("rbw_ctr", dbg_ctr, 2'b10);
        tick();
        pred_valid = 0;
        check("rbw_next_pt", pred_taken, 1);
        check_all();

        do_reset();
        for (int i = 0; i < 10; i++) begin
            upd_outcome = 1'($urandom);
            upd(4'($urandom), upd_outcome, upd_outcome ^ miss_pat[i]);
        end
        check("stat10_upd", stat_upd, 10);
        check("stat10_miss", stat_miss, 3);
        upd_valid = 1; upd_outcome = 1; upd_pred = 1;
        for (int i = 0; i < 70000; i++) begin upd_idx = 4'($urandom); tick(); end
        upd_valid = 0;
        check("stat_sat", stat_upd, 16'hffff);
        upd(3, 0, 1);
        check("stat_hold", stat_upd, 16'hffff);
        check_all();

        do_reset();
        for (int c = 0; c < 400; c++) begin
            reset       = ($urandom_range(0, 59) != 0);
            pred_valid  = 1'($urandom);
            pred_pc     = 2'($urandom);
            upd_valid   = 1'($urandom);
            upd_idx     = 4'($urandom);
            upd_outcome = 1'($urandom);
            upd_pred    = 1'($urandom);
            tick();
            check_all();
        end

        reset = 1; pred_valid = 1; upd_valid = 1;
        for (int c = 0; c < 12; c++) begin
            pred_pc = 2'($urandom); upd_idx = 4'($urandom);
            upd_outcome = 1'($urandom); upd_pred = 1'($urandom);
            reset = (c != 6);
            tick();
            if (c == 6) begin
                check("mid_pov", pred_out_valid, 0);
                check("mid_ghr", laststates, 0);
                check("mid_upd", stat_upd, 0);
                check("mid_miss", stat_miss, 0);
            end
            if (c == 7) check("mid_resume", pred_out_valid, 1);
            check_all();
        end
        pred_valid = 0; upd_valid = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
